// File: rtl/qam_demapper_if.sv
// Valid/ready bus between the equaliser, the QAM demapper and the bit deserialiser.
// The out_err field exists only when QAM_DEMAPPER_EVM_EN is defined.
interface qam_demapper_if #(
    parameter int SAMPLE_WIDTH = 12,
    parameter int SYM_W        = 4
);
    logic                           in_valid;
    logic                           in_ready;
    logic signed [SAMPLE_WIDTH-1:0] in_i;
    logic signed [SAMPLE_WIDTH-1:0] in_q;
    logic                           out_valid;
    logic                           out_ready;
    logic [SYM_W-1:0]               out_sym;
    logic                           out_clip;
    logic [15:0]                    sym_count;
`ifdef QAM_DEMAPPER_EVM_EN
    logic [SAMPLE_WIDTH:0]          out_err;

    modport slave (
        input  in_valid, in_i, in_q, out_ready,
        output in_ready, out_valid, out_sym, out_clip, sym_count, out_err
    );
    modport master (
        output in_valid, in_i, in_q, out_ready,
        input  in_ready, out_valid, out_sym, out_clip, sym_count, out_err
    );
`else
    modport slave (
        input  in_valid, in_i, in_q, out_ready,
        output in_ready, out_valid, out_sym, out_clip, sym_count
    );
    modport master (
        output in_valid, in_i, in_q, out_ready,
        input  in_ready, out_valid, out_sym, out_clip, sym_count
    );
`endif
endinterface

// File: rtl/qam_demapper.sv
// Hard-decision square-QAM demapper: slices I/Q to the nearest grid point and emits
// its Gray-coded index through a two-stage pipeline. Optional EVM output: QAM_DEMAPPER_EVM_EN.
module qam_demapper #(
    parameter int POINTS       = 16,
    parameter int SAMPLE_WIDTH = 12,
    parameter int FRAC_BITS    = 4
) (
    input  logic          clk,
    input  logic          rst,
    qam_demapper_if.slave bus
);
    localparam int SYM_W = $clog2(POINTS);
    localparam int CW    = SYM_W / 2;
    localparam int SIDE  = 1 << CW;
    localparam int B     = SIDE - 1;
    localparam int XW    = SAMPLE_WIDTH + 2;

    localparam logic signed [XW-1:0]   SIDE_X   = XW'(SIDE);
    localparam logic signed [XW-1:0]   B_X      = XW'(B);
    localparam logic [SAMPLE_WIDTH:0]  CLIP_LIM = (SAMPLE_WIDTH + 1)'((B + 1) << FRAC_BITS);

    if (POINTS != 4 && POINTS != 16 && POINTS != 64 && POINTS != 256) begin : g_bad_points
        $error("qam_demapper: POINTS must be 4, 16, 64 or 256");
    end

    // Floor to grid units, offset by SIDE, halve and clamp: picks the nearest odd level,
    // with exact even boundaries resolving upward.
    function automatic logic [CW-1:0] slice_axis(input logic signed [SAMPLE_WIDTH-1:0] x);
        logic signed [XW-1:0] xe;
        logic signed [XW-1:0] t;
        logic signed [XW-1:0] h;
        logic [CW-1:0]        res;
        xe = {{2{x[SAMPLE_WIDTH-1]}}, x};
        t  = (xe >>> FRAC_BITS) + SIDE_X;
        h  = t >>> 1;
        if (h[XW-1]) begin
            res = '0;
        end else if (h > B_X) begin
            res = CW'(B);
        end else begin
            res = h[CW-1:0];
        end
        return res;
    endfunction

    // Magnitude is formed one bit wider so the most negative sample does not wrap.
    function automatic logic over_limit(input logic signed [SAMPLE_WIDTH-1:0] x);
        logic signed [SAMPLE_WIDTH:0] xe;
        logic [SAMPLE_WIDTH:0]        mag;
        xe  = {x[SAMPLE_WIDTH-1], x};
        mag = xe[SAMPLE_WIDTH] ? $unsigned(-xe) : $unsigned(xe);
        return (mag > CLIP_LIM);
    endfunction

    function automatic logic [SYM_W-1:0] gray_code(input logic [SYM_W-1:0] a);
        return a ^ (a >> 1);
    endfunction

`ifdef QAM_DEMAPPER_EVM_EN
    function automatic logic [SAMPLE_WIDTH:0] evm_metric(
        input logic signed [SAMPLE_WIDTH-1:0] x,
        input logic signed [SAMPLE_WIDTH-1:0] y,
        input logic [CW-1:0]                  c,
        input logic [CW-1:0]                  r
    );
        int dx;
        int dy;
        int sum;
        int max_err;
        max_err = (1 << (SAMPLE_WIDTH + 1)) - 1;
        dx  = int'(x) - ((2 * int'(c) - B) * (1 << FRAC_BITS));
        dy  = int'(y) - ((2 * int'(r) - B) * (1 << FRAC_BITS));
        sum = ((dx < 0) ? -dx : dx) + ((dy < 0) ? -dy : dy);
        if (sum > max_err) begin
            sum = max_err;
        end else begin
            sum = sum;
        end
        return (SAMPLE_WIDTH + 1)'(sum);
    endfunction
`endif

    logic          adv_s;
    logic [CW-1:0] c_s;
    logic [CW-1:0] r_s;
    logic          clip_s;

    logic          s1_valid_r;
    logic [CW-1:0] s1_c_r;
    logic [CW-1:0] s1_r_r;
    logic          s1_clip_r;

    logic             out_valid_r;
    logic [SYM_W-1:0] out_sym_r;
    logic             out_clip_r;
    logic [15:0]      sym_count_r;

`ifdef QAM_DEMAPPER_EVM_EN
    logic signed [SAMPLE_WIDTH-1:0] s1_i_r;
    logic signed [SAMPLE_WIDTH-1:0] s1_q_r;
    logic [SAMPLE_WIDTH:0]          out_err_r;
`endif

    // Whole pipeline advances together whenever the output slot is free or being drained.
    always_comb begin
        adv_s  = !out_valid_r || bus.out_ready;
        c_s    = slice_axis(bus.in_i);
        r_s    = slice_axis(bus.in_q);
        clip_s = over_limit(bus.in_i) || over_limit(bus.in_q);
    end

    // Stage 1: per-axis decisions and clip flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_c_r     <= '0;
            s1_r_r     <= '0;
            s1_clip_r  <= 1'b0;
`ifdef QAM_DEMAPPER_EVM_EN
            s1_i_r     <= '0;
            s1_q_r     <= '0;
`endif
        end else if (adv_s) begin
            s1_valid_r <= bus.in_valid;
            s1_c_r     <= c_s;
            s1_r_r     <= r_s;
            s1_clip_r  <= clip_s;
`ifdef QAM_DEMAPPER_EVM_EN
            s1_i_r     <= bus.in_i;
            s1_q_r     <= bus.in_q;
`endif
        end else begin
            s1_valid_r <= s1_valid_r;
        end
    end

    // Stage 2: Gray-coded symbol of the linear address r*SIDE + c.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_sym_r   <= '0;
            out_clip_r  <= 1'b0;
`ifdef QAM_DEMAPPER_EVM_EN
            out_err_r   <= '0;
`endif
        end else if (adv_s) begin
            out_valid_r <= s1_valid_r;
            out_sym_r   <= gray_code({s1_r_r, s1_c_r});
            out_clip_r  <= s1_clip_r;
`ifdef QAM_DEMAPPER_EVM_EN
            out_err_r   <= evm_metric(s1_i_r, s1_q_r, s1_c_r, s1_r_r);
`endif
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    // Delivered-symbol counter, wrapping at 16 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sym_count_r <= 16'd0;
        end else if (out_valid_r && bus.out_ready) begin
            sym_count_r <= sym_count_r + 16'd1;
        end else begin
            sym_count_r <= sym_count_r;
        end
    end

    assign bus.in_ready  = adv_s;
    assign bus.out_valid = out_valid_r;
    assign bus.out_sym   = out_sym_r;
    assign bus.out_clip  = out_clip_r;
    assign bus.sym_count = sym_count_r;
`ifdef QAM_DEMAPPER_EVM_EN
    assign bus.out_err   = out_err_r;
`endif

endmodule

// File: tb/tb_qam_demapper.sv
// Scoreboard bench for qam_demapper (POINTS=16, SAMPLE_WIDTH=12, FRAC_BITS=4).
module tb_qam_demapper;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    qam_demapper_if #(.SAMPLE_WIDTH(12), .SYM_W(4)) bus ();

    qam_demapper #(.POINTS(16), .SAMPLE_WIDTH(12), .FRAC_BITS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [3:0] sym;
        logic       clip;
        int         err;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;
    logic [3:0] gray_tab [16] = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
                                  4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Independent reference: nearest of the four odd levels, ties to the upper one.
    function automatic int nearest(input int x);
        int best = 0;
        int bd = 1 << 30;
        for (int k = 0; k < 4; k++) begin
            int v = (2 * k - 3) * 16;
            int d = (x > v) ? x - v : v - x;
            if (d <= bd) begin
                bd = d;
                best = k;
            end
        end
        return best;
    endfunction

    // Monitor: compares every delivered symbol with the oldest expectation.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_output", 32'(bus.out_sym), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("out_sym", 32'(bus.out_sym), 32'(e.sym));
                check("out_clip", 32'(bus.out_clip), 32'(e.clip));
`ifdef QAM_DEMAPPER_EVM_EN
                if (e.err >= 0) check("out_err", 32'(bus.out_err), 32'(e.err));
`endif
            end
        end
    end

    task automatic send(input logic signed [11:0] i, input logic signed [11:0] q,
                        input logic [3:0] esym, input logic eclip, input int eerr);
        logic acc;
        int k;
        exp_t e;
        bus.in_valid = 1'b1;
        bus.in_i = i;
        bus.in_q = q;
        k = 0;
        acc = 1'b0;
        do begin
            @(negedge clk);
            acc = bus.in_ready;
            if (acc) begin
                e.sym = esym;
                e.clip = eclip;
                e.err = eerr;
                sb.push_back(e);
            end
            @(posedge clk);
            #1;
            k++;
        end while (!acc && k < 50);
        if (!acc) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_model(input logic signed [11:0] i, input logic signed [11:0] q);
        int c, r, a;
        logic clip;
        c = nearest(int'(i));
        r = nearest(int'(q));
        a = r * 4 + c;
        clip = (int'(i) > 64) || (int'(i) < -64) || (int'(q) > 64) || (int'(q) < -64);
        send(i, q, 4'(a ^ (a >> 1)), clip, -1);
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 100 && sb.size() != 0; k++) @(posedge clk);
        @(posedge clk);
        #1;
        check("drain", 32'(sb.size()), 32'd0);
    endtask

    task automatic do_reset();
        bus.in_valid = 1'b0;
        rst = 1'b1;
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_i = 12'sd0;
        bus.in_q = 12'sd0;
        bus.out_ready = 1'b1;
        do_reset();

        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_sym", 32'(bus.out_sym), 32'd0);
        check("rst_out_clip", 32'(bus.out_clip), 32'd0);
        check("rst_sym_count", 32'(bus.sym_count), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);

        // Exact grid sweep, row-major: x = (2c-3)*16, y = (2r-3)*16.
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                send(12'((2 * c - 3) * 16), 12'((2 * r - 3) * 16), gray_tab[r * 4 + c], 1'b0, -1);
            end
        end
        // Decision boundaries.
        send(12'sh000, -12'sh020, 4'd5, 1'b0, -1);
        send(-12'sh001, -12'sh021, 4'd1, 1'b0, -1);
        // Clipping.
        send(12'sh050, 12'sh030, 4'd8, 1'b1, -1);
        send(-12'sh800, -12'sh800, 4'd0, 1'b1, -1);
        bus.in_valid = 1'b0;
        wait_drain();
        check("sweep_count", 32'(bus.sym_count), 32'd20);

        // Backpressure: 10 back-to-back samples, out_ready low for 3 cycles.
        do_reset();
        fork
            begin
                for (int n = 0; n < 10; n++) begin
                    send_model(12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)));
                end
                bus.in_valid = 1'b0;
            end
            begin
                repeat (4) @(posedge clk);
                #1;
                bus.out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
                end
                @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        wait_drain();
        check("bp_sym_count", 32'(bus.sym_count), 32'd10);

        // Asynchronous reset with two symbols in flight.
        send(-12'sd48, -12'sd48, 4'd0, 1'b0, -1);
        send(12'sd16, -12'sd48, 4'd3, 1'b0, -1);
        bus.in_valid = 1'b0;
        check("pre_rst_out_valid", 32'(bus.out_valid), 32'd1);
        rst = 1'b1;
        sb.delete();
        #1;
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_sym_count", 32'(bus.sym_count), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        send(12'sd48, 12'sd48, 4'd8, 1'b0, -1);
        bus.in_valid = 1'b0;
        check("lat_after_1_edge", 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        #1;
        check("lat_after_2_edges", 32'(bus.out_valid), 32'd1);
        wait_drain();
        check("post_rst_count", 32'(bus.sym_count), 32'd1);

`ifdef QAM_DEMAPPER_EVM_EN
        // |2047-48| + |2047-48| = 3998.
        send(12'sh014, -12'sh030, 4'd3, 1'b0, 4);
        send(12'sh7FF, 12'sh7FF, 4'd8, 1'b1, 3998);
        bus.in_valid = 1'b0;
        wait_drain();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
